// File: rtl/issue_queue_pkg.sv
// Shared types and CDB wakeup helper for the parametrised issue queue.
// Storage types are sized at the package widths; the top zero-extends narrower configs.
package issue_queue_pkg;

   localparam int unsigned IQ_TAG_W  = 6;
   localparam int unsigned IQ_DATA_W = 32;
   localparam int unsigned IQ_CMN_W  = 16;

   typedef struct packed {
      logic [IQ_TAG_W-1:0]  tag;
      logic                 rdy;
      logic [IQ_DATA_W-1:0] data;
   } iq_operand_t;

   typedef struct packed {
      logic                valid;
      logic [IQ_CMN_W-1:0] cmn;
      iq_operand_t         rs1;
      iq_operand_t         rs2;
   } iq_entry_t;

   // An operand that is already ready never re-captures broadcast data.
   function automatic iq_operand_t operand_wakeup(input iq_operand_t          op,
                                                  input logic                 cdb_valid,
                                                  input logic [IQ_TAG_W-1:0]  cdb_tag,
                                                  input logic [IQ_DATA_W-1:0] cdb_data);
      iq_operand_t res;
      res = op;
      if (cdb_valid && !op.rdy && (op.tag == cdb_tag)) begin
         res.rdy  = 1'b1;
         res.data = cdb_data;
      end
      return res;
   endfunction

endpackage

// File: rtl/iq_oldest_ready_sel.sv
// Priority encoder: lowest set index of i_ready plus a found flag.
module iq_oldest_ready_sel #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] i_ready,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_found
);

   always_comb begin
      o_found = |i_ready;
      o_idx   = '0;
      // Scan downwards so the lowest (oldest) index wins.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i_ready[i]) o_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/issue_queue_param.sv
// Compacting issue queue: CDB wakeup, oldest-ready select, valid/ready issue.
// Optional ISSUE_QUEUE_PERF_EN adds o_occupancy and a saturating o_stall_cnt.
module issue_queue_param
   import issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TAG_W  = 6,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CMN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_disp_valid,
   output logic              o_disp_ready,
   input  logic [CMN_W-1:0]  i_disp_cmn,
   input  logic [TAG_W-1:0]  i_disp_rs1_tag,
   input  logic [TAG_W-1:0]  i_disp_rs2_tag,
   input  logic              i_disp_rs1_rdy,
   input  logic              i_disp_rs2_rdy,
   input  logic [DATA_W-1:0] i_disp_rs1_data,
   input  logic [DATA_W-1:0] i_disp_rs2_data,
   input  logic              i_cdb_valid,
   input  logic [TAG_W-1:0]  i_cdb_tag,
   input  logic [DATA_W-1:0] i_cdb_data,
   output logic              o_iss_valid,
   input  logic              i_iss_ready,
   output logic [CMN_W-1:0]  o_iss_cmn,
   output logic [DATA_W-1:0] o_iss_rs1_data,
   output logic [DATA_W-1:0] o_iss_rs2_data,
   output logic              o_queue_full
`ifdef ISSUE_QUEUE_PERF_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
   output logic [15:0]                o_stall_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   iq_entry_t              r_entries [DEPTH];
   iq_entry_t              w_woken   [DEPTH];
   iq_entry_t              w_next    [DEPTH];
   iq_entry_t              w_disp_entry;
   logic [CNT_W-1:0]       r_count;
   logic [CNT_W-1:0]       w_count_next;
   logic [CNT_W-1:0]       w_wr_idx;
   logic [DEPTH-1:0]       w_ready;
   logic [IDX_W-1:0]       w_sel_idx;
   logic                   w_found;
   logic                   w_iss_fire;
   logic                   w_disp_fire;
   logic [IQ_TAG_W-1:0]    w_cdb_tag;
   logic [IQ_DATA_W-1:0]   w_cdb_data;

   assign w_cdb_tag  = IQ_TAG_W'(i_cdb_tag);
   assign w_cdb_data = IQ_DATA_W'(i_cdb_data);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i] = r_entries[i].valid & r_entries[i].rs1.rdy & r_entries[i].rs2.rdy;
      end
   end

   iq_oldest_ready_sel #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_sel (
      .i_ready (w_ready),
      .o_idx   (w_sel_idx),
      .o_found (w_found)
   );

   assign o_disp_ready = (r_count < CNT_W'(DEPTH));
   assign o_queue_full = (r_count == CNT_W'(DEPTH));
   assign o_iss_valid  = w_found;
   assign w_iss_fire   = w_found & i_iss_ready;
   assign w_disp_fire  = i_disp_valid & o_disp_ready;
   assign w_wr_idx     = r_count - CNT_W'(w_iss_fire);
   assign w_count_next = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_fire);

   assign o_iss_cmn      = w_found ? CMN_W'(r_entries[w_sel_idx].cmn) : '0;
   assign o_iss_rs1_data = w_found ? DATA_W'(r_entries[w_sel_idx].rs1.data) : '0;
   assign o_iss_rs2_data = w_found ? DATA_W'(r_entries[w_sel_idx].rs2.data) : '0;

   // Incoming entry gets the same CDB treatment so a same-cycle broadcast is not lost.
   always_comb begin
      w_disp_entry       = '0;
      w_disp_entry.valid = 1'b1;
      w_disp_entry.cmn   = IQ_CMN_W'(i_disp_cmn);
      w_disp_entry.rs1   = operand_wakeup('{tag: IQ_TAG_W'(i_disp_rs1_tag), rdy: i_disp_rs1_rdy,
                                            data: IQ_DATA_W'(i_disp_rs1_data)},
                                          i_cdb_valid, w_cdb_tag, w_cdb_data);
      w_disp_entry.rs2   = operand_wakeup('{tag: IQ_TAG_W'(i_disp_rs2_tag), rdy: i_disp_rs2_rdy,
                                            data: IQ_DATA_W'(i_disp_rs2_data)},
                                          i_cdb_valid, w_cdb_tag, w_cdb_data);
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_woken[i] = r_entries[i];
         if (r_entries[i].valid) begin
            w_woken[i].rs1 = operand_wakeup(r_entries[i].rs1, i_cdb_valid, w_cdb_tag, w_cdb_data);
            w_woken[i].rs2 = operand_wakeup(r_entries[i].rs2, i_cdb_valid, w_cdb_tag, w_cdb_data);
         end
      end
   end

   // Compaction: on issue everything above the selected slot slides down one, woken state intact.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) w_next[i] = w_woken[i];
      if (w_iss_fire) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(w_sel_idx)) w_next[i] = w_woken[i+1];
         end
         w_next[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (w_disp_fire && (CNT_W'(i) == w_wr_idx)) w_next[i] = w_disp_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      end else if (i_flush) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      end else begin
         r_count <= w_count_next;
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= w_next[i];
      end
   end

`ifdef ISSUE_QUEUE_PERF_EN
   logic [15:0] r_stall_cnt;

   // Survives flush on purpose; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (i_disp_valid && !o_disp_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign o_occupancy = r_count;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed self-checking bench for issue_queue_param at DEPTH=4.
// Define ISSUE_QUEUE_PERF_EN to also check o_occupancy and o_stall_cnt.
module tb_issue_queue_param;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [15:0] disp_cmn;
   logic [5:0]  disp_rs1_tag;
   logic [5:0]  disp_rs2_tag;
   logic        disp_rs1_rdy;
   logic        disp_rs2_rdy;
   logic [31:0] disp_rs1_data;
   logic [31:0] disp_rs2_data;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        iss_valid;
   logic        iss_ready;
   logic [15:0] iss_cmn;
   logic [31:0] iss_rs1_data;
   logic [31:0] iss_rs2_data;
   logic        queue_full;
`ifdef ISSUE_QUEUE_PERF_EN
   logic [2:0]  occupancy;
   logic [15:0] stall_cnt;
`endif

   int total;
   int bad;

   issue_queue_param #(
      .DEPTH  (4),
      .TAG_W  (6),
      .DATA_W (32),
      .CMN_W  (16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_flush         (flush),
      .i_disp_valid    (disp_valid),
      .o_disp_ready    (disp_ready),
      .i_disp_cmn      (disp_cmn),
      .i_disp_rs1_tag  (disp_rs1_tag),
      .i_disp_rs2_tag  (disp_rs2_tag),
      .i_disp_rs1_rdy  (disp_rs1_rdy),
      .i_disp_rs2_rdy  (disp_rs2_rdy),
      .i_disp_rs1_data (disp_rs1_data),
      .i_disp_rs2_data (disp_rs2_data),
      .i_cdb_valid     (cdb_valid),
      .i_cdb_tag       (cdb_tag),
      .i_cdb_data      (cdb_data),
      .o_iss_valid     (iss_valid),
      .i_iss_ready     (iss_ready),
      .o_iss_cmn       (iss_cmn),
      .o_iss_rs1_data  (iss_rs1_data),
      .o_iss_rs2_data  (iss_rs2_data),
      .o_queue_full    (queue_full)
`ifdef ISSUE_QUEUE_PERF_EN
      ,
      .o_occupancy     (occupancy),
      .o_stall_cnt     (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush         = 1'b0;
      disp_valid    = 1'b0;
      disp_cmn      = '0;
      disp_rs1_tag  = '0;
      disp_rs2_tag  = '0;
      disp_rs1_rdy  = 1'b0;
      disp_rs2_rdy  = 1'b0;
      disp_rs1_data = '0;
      disp_rs2_data = '0;
      cdb_valid     = 1'b0;
      cdb_tag       = '0;
      cdb_data      = '0;
      iss_ready     = 1'b0;
   endtask

   task automatic drive_disp(input logic [15:0] cmn,
                             input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                             input logic [5:0] t2, input logic r2, input logic [31:0] d2);
      disp_valid    = 1'b1;
      disp_cmn      = cmn;
      disp_rs1_tag  = t1;
      disp_rs1_rdy  = r1;
      disp_rs1_data = d1;
      disp_rs2_tag  = t2;
      disp_rs2_rdy  = r2;
      disp_rs2_data = d2;
   endtask

   task automatic drive_cdb(input logic [5:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
      total++; if (disp_ready !== 1'b1) begin bad++;
         $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
      total++; if (queue_full !== 1'b0) begin bad++;
         $display("FAIL reset_queue_full got=%b exp=0", queue_full); end
      total++; if ({iss_cmn, iss_rs1_data, iss_rs2_data} !== 80'h0) begin bad++;
         $display("FAIL reset_iss_data got=%h/%h/%h exp=0", iss_cmn, iss_rs1_data, iss_rs2_data);
      end
   endtask

   task automatic test_latency();
      drive_disp(16'hA1, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22);
      step();
      disp_valid = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_cmn !== 16'hA1) begin bad++;
         $display("FAIL latency_issue got=%b/%h exp=1/00a1", iss_valid, iss_cmn); end
      total++; if (iss_rs1_data !== 32'h11 || iss_rs2_data !== 32'h22) begin bad++;
         $display("FAIL latency_data got=%h/%h exp=11/22", iss_rs1_data, iss_rs2_data); end
      iss_ready = 1'b1;
      step();
      total++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin bad++;
         $display("FAIL latency_drain got=%b/%b exp=0/1", iss_valid, disp_ready); end
      // Empty queue with iss_ready held: nothing changes.
      step();
      iss_ready = 1'b0;
      total++; if (iss_valid !== 1'b0 || queue_full !== 1'b0 || iss_cmn !== 16'h0) begin bad++;
         $display("FAIL empty_issue got=%b/%b/%h exp=0/0/0", iss_valid, queue_full, iss_cmn); end
   endtask

   task automatic test_wakeup();
      drive_disp(16'hB0, 6'd5, 1'b0, 32'h0, 6'd3, 1'b1, 32'h2);
      step();
      disp_valid = 1'b0;
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL wakeup_not_ready got=%b exp=0", iss_valid); end
      step();
      drive_cdb(6'd5, 32'hDEAD);
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL wakeup_same_cycle got=%b exp=0", iss_valid); end
      step();
      cdb_valid = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_rs1_data !== 32'hDEAD || iss_rs2_data !== 32'h2)
         begin bad++;
         $display("FAIL wakeup_issue got=%b/%h/%h exp=1/dead/2", iss_valid, iss_rs1_data,
                  iss_rs2_data); end
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      // rs1 already ready must keep its data; rs2 with the same tag wakes.
      drive_disp(16'hB1, 6'd9, 1'b1, 32'h111, 6'd9, 1'b0, 32'h0);
      step();
      disp_valid = 1'b0;
      drive_cdb(6'd9, 32'h999);
      step();
      cdb_valid = 1'b0;
      total++; if (iss_rs1_data !== 32'h111 || iss_rs2_data !== 32'h999) begin bad++;
         $display("FAIL wakeup_rdy_kept got=%h/%h exp=111/999", iss_rs1_data, iss_rs2_data); end
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      // Both operands on the same tag.
      drive_disp(16'hB2, 6'd12, 1'b0, 32'h0, 6'd12, 1'b0, 32'h0);
      step();
      disp_valid = 1'b0;
      drive_cdb(6'd12, 32'hCAFE);
      step();
      cdb_valid = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_rs1_data !== 32'hCAFE || iss_rs2_data !== 32'hCAFE)
         begin bad++;
         $display("FAIL wakeup_both got=%b/%h/%h exp=1/cafe/cafe", iss_valid, iss_rs1_data,
                  iss_rs2_data); end
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
   endtask

   task automatic test_bypass();
      drive_disp(16'hC0, 6'd7, 1'b0, 32'h0, 6'd8, 1'b1, 32'h88);
      drive_cdb(6'd7, 32'h1234);
      step();
      disp_valid = 1'b0;
      cdb_valid  = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_rs1_data !== 32'h1234 || iss_cmn !== 16'hC0)
         begin bad++;
         $display("FAIL bypass got=%b/%h/%h exp=1/1234/00c0", iss_valid, iss_rs1_data, iss_cmn);
      end
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      drive_disp(16'hD0, 6'd1, 1'b1, 32'hD0, 6'd1, 1'b1, 32'hD0);
      step();
      // Issue D0 while D1 dispatches: D1 lands in slot 0, count stays 1.
      drive_disp(16'hD1, 6'd1, 1'b1, 32'hD1, 6'd1, 1'b1, 32'hD1);
      iss_ready = 1'b1;
      step();
      disp_valid = 1'b0;
      iss_ready  = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_cmn !== 16'hD1) begin bad++;
         $display("FAIL b2b_slot0 got=%b/%h exp=1/00d1", iss_valid, iss_cmn); end
`ifdef ISSUE_QUEUE_PERF_EN
      total++; if (occupancy !== 3'd1) begin bad++;
         $display("FAIL b2b_occupancy got=%0d exp=1", occupancy); end
`endif
      iss_ready = 1'b1;
      step();
      iss_ready = 1'b0;
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL b2b_empty got=%b exp=0", iss_valid); end
   endtask

   task automatic test_oldest_first();
      drive_disp(16'h10, 6'd20, 1'b0, 32'h0, 6'd0, 1'b1, 32'hB0);
      step();
      drive_disp(16'h11, 6'd0, 1'b1, 32'hA1, 6'd0, 1'b1, 32'hB1);
      step();
      drive_disp(16'h12, 6'd21, 1'b0, 32'h0, 6'd0, 1'b1, 32'hB2);
      step();
      drive_disp(16'h13, 6'd0, 1'b1, 32'hA3, 6'd0, 1'b1, 32'hB3);
      step();
      disp_valid = 1'b0;
      total++; if (queue_full !== 1'b1 || disp_ready !== 1'b0) begin bad++;
         $display("FAIL oldest_full got=%b/%b exp=1/0", queue_full, disp_ready); end
      total++; if (iss_cmn !== 16'h11 || iss_rs1_data !== 32'hA1) begin bad++;
         $display("FAIL oldest_first got=%h/%h exp=0011/a1", iss_cmn, iss_rs1_data); end
      iss_ready = 1'b1;
      step();
      total++; if (iss_valid !== 1'b1 || iss_cmn !== 16'h13 || queue_full !== 1'b0) begin bad++;
         $display("FAIL oldest_second got=%b/%h/%b exp=1/0013/0", iss_valid, iss_cmn, queue_full);
      end
      step();
      iss_ready = 1'b0;
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL oldest_none_ready got=%b exp=0", iss_valid); end
`ifdef ISSUE_QUEUE_PERF_EN
      total++; if (occupancy !== 3'd2) begin bad++;
         $display("FAIL oldest_occupancy got=%0d exp=2", occupancy); end
`endif
      drive_cdb(6'd20, 32'h2020);
      step();
      // Issue slot 0 while slot 1 shifts down and wakes in the same edge.
      drive_cdb(6'd21, 32'h2121);
      iss_ready = 1'b1;
      total++; if (iss_cmn !== 16'h10 || iss_rs1_data !== 32'h2020) begin bad++;
         $display("FAIL oldest_wake0 got=%h/%h exp=0010/2020", iss_cmn, iss_rs1_data); end
      step();
      cdb_valid = 1'b0;
      total++; if (iss_valid !== 1'b1 || iss_cmn !== 16'h12 || iss_rs1_data !== 32'h2121)
         begin bad++;
         $display("FAIL shift_wake got=%b/%h/%h exp=1/0012/2121", iss_valid, iss_cmn,
                  iss_rs1_data); end
      step();
      iss_ready = 1'b0;
      total++; if (iss_valid !== 1'b0 || disp_ready !== 1'b1) begin bad++;
         $display("FAIL oldest_drained got=%b/%b exp=0/1", iss_valid, disp_ready); end
   endtask

   task automatic test_full_simul();
      logic [15:0] exp_order [4];
      exp_order = '{16'h41, 16'h42, 16'h43, 16'h50};
      for (int k = 0; k < 4; k++) begin
         drive_disp(16'h40 + 16'(k), 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
         step();
      end
      disp_valid = 1'b0;
      total++; if (queue_full !== 1'b1) begin bad++;
         $display("FAIL simul_full got=%b exp=1", queue_full); end
      iss_ready = 1'b1;
      drive_disp(16'h50, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
      step();
      iss_ready = 1'b0;
      total++; if (queue_full !== 1'b0 || disp_ready !== 1'b1 || iss_cmn !== 16'h41) begin bad++;
         $display("FAIL simul_refused got=%b/%b/%h exp=0/1/0041", queue_full, disp_ready,
                  iss_cmn); end
`ifdef ISSUE_QUEUE_PERF_EN
      total++; if (occupancy !== 3'd3) begin bad++;
         $display("FAIL simul_occ3 got=%0d exp=3", occupancy); end
`endif
      step();
      disp_valid = 1'b0;
      total++; if (queue_full !== 1'b1) begin bad++;
         $display("FAIL simul_accepted got=%b exp=1", queue_full); end
      iss_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++; if (iss_valid !== 1'b1 || iss_cmn !== exp_order[k]) begin bad++;
            $display("FAIL simul_drain%0d got=%b/%h exp=1/%h", k, iss_valid, iss_cmn,
                     exp_order[k]); end
         step();
      end
      iss_ready = 1'b0;
      total++; if (iss_valid !== 1'b0) begin bad++;
         $display("FAIL simul_empty got=%b exp=0", iss_valid); end
   endtask

   task automatic test_reset_mid_run();
      for (int k = 0; k < 3; k++) begin
         drive_disp(16'h60 + 16'(k), 6'd0, 1'b1, 32'h6, 6'd0, 1'b1, 32'h6);
         step();
      end
      disp_valid = 1'b0;
      total++; if (iss_valid !== 1'b1) begin bad++;
         $display("FAIL midrst_pre got=%b exp=1", iss_valid); end
      #3;
      rst_n = 1'b0;
      #1;
      total++; if (iss_valid !== 1'b0 || queue_full !== 1'b0 || disp_ready !== 1'b1) begin bad++;
         $display("FAIL midrst_async got=%b/%b/%b exp=0/0/1", iss_valid, queue_full, disp_ready);
      end
      rst_n = 1'b1;
      step();
      total++; if (iss_valid !== 1'b0 || iss_cmn !== 16'h0) begin bad++;
         $display("FAIL midrst_after got=%b/%h exp=0/0", iss_valid, iss_cmn); end
   endtask

   task automatic test_flush();
      apply_reset();
      for (int k = 0; k < 9; k++) begin
         drive_disp(16'h70 + 16'(k), 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'h7);
         step();
      end
      disp_valid = 1'b0;
      total++; if (queue_full !== 1'b1 || iss_valid !== 1'b0) begin bad++;
         $display("FAIL flush_pre got=%b/%b exp=1/0", queue_full, iss_valid); end
`ifdef ISSUE_QUEUE_PERF_EN
      total++; if (stall_cnt !== 16'd5) begin bad++;
         $display("FAIL stall_five got=%0d exp=5", stall_cnt); end
`endif
      flush = 1'b1;
      drive_cdb(6'd30, 32'h3030);
      drive_disp(16'h7F, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0);
      step();
      idle_inputs();
      total++; if (iss_valid !== 1'b0 || queue_full !== 1'b0 || disp_ready !== 1'b1) begin bad++;
         $display("FAIL flush_clear got=%b/%b/%b exp=0/0/1", iss_valid, queue_full, disp_ready);
      end
`ifdef ISSUE_QUEUE_PERF_EN
      total++; if (occupancy !== 3'd0) begin bad++;
         $display("FAIL flush_occ got=%0d exp=0", occupancy); end
      // Queue was still full during the flush cycle, so that cycle also counts as a stall.
      total++; if (stall_cnt !== 16'd6) begin bad++;
         $display("FAIL stall_kept got=%0d exp=6", stall_cnt); end
`endif
      step();
      total++; if (iss_valid !== 1'b0 || iss_cmn !== 16'h0) begin bad++;
         $display("FAIL flush_stays_empty got=%b/%h exp=0/0", iss_valid, iss_cmn); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle_inputs();
      #1;
      test_reset();
      #6;
      rst_n = 1'b1;
      step();
      test_latency();
      test_wakeup();
      test_bypass();
      test_back_to_back();
      test_oldest_first();
      test_full_simul();
      test_reset_mid_run();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
- Parametrised successor to the fixed 4-entry issue controller. Combines entry storage and control in one block.
- Holds up to DEPTH dispatched instructions and wakes operands from the CDB by tag match. Issues the oldest ready entry to one execution unit over a valid/ready handshake.
- Storage is compacting: index 0 is always the oldest entry, with no holes.
- Sits between the dispatch unit and one execution unit. One instance per functional unit.

Parameters:
- DEPTH, 4: number of entries; legal range 2..16.
- TAG_W, 6: physical tag width.
- DATA_W, 32: operand data width.
- CMN_W, 16: common payload width (opcode, rd tag, etc.); passed through untouched.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; invalidates all entries.
- disp_valid  in  1  dispatch offers an instruction.
- disp_ready  out  1  queue accepts; equals (count < DEPTH).
- disp_cmn  in  CMN_W  common payload.
- disp_rs1_tag / disp_rs2_tag  in  TAG_W  source tags.
- disp_rs1_rdy / disp_rs2_rdy  in  1  operand already valid at dispatch.
- disp_rs1_data / disp_rs2_data  in  DATA_W  operand data, meaningful when rdy=1.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast data.
- iss_valid  out  1  an entry with both operands ready is presented.
- iss_ready  in  1  execution unit accepts.
- iss_cmn  out  CMN_W  selected entry payload.
- iss_rs1_data / iss_rs2_data  out  DATA_W  selected entry operands.
- queue_full  out  1  count == DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entry valid and rdy bits clear; count = 0.
  - Outputs: iss_valid=0, disp_ready=1, queue_full=0, iss_* data=0.
- Entry state is {valid, cmn, rs1_tag, rs1_rdy, rs1_data, rs2_tag, rs2_rdy, rs2_data}. Valid entries occupy indices 0..count-1.
- Wakeup, every cycle:
  - An operand matches when cdb_valid=1, its entry is valid, its rdy=0, and its tag == cdb_tag.
  - On match, set rdy=1 and capture cdb_data at the clock edge.
  - An operand with rdy=1 never matches.
  - Wakeup also applies to the entry's new position when it shifts in the same cycle.
- Select (combinational from registered state):
  - Pick the lowest index i with valid, rs1_rdy and rs2_rdy all set.
  - iss_valid = any such i exists. iss_* is driven from entry i; zeros when iss_valid=0.
  - An entry woken this cycle is eligible next cycle at the earliest; there is no same-cycle wakeup-to-issue.
- Issue fire = iss_valid & iss_ready:
  - The selected entry is removed at the edge.
  - Entries above it move down by one, carrying any same-cycle wakeup.
  - iss_valid must not depend combinationally on iss_ready.
- Dispatch fire = disp_valid & disp_ready:
  - The new entry is written at index count, or count-1 if an issue fires in the same cycle.
  - Dispatch bypass: if cdb_valid=1, a disp operand has rdy=0, and its tag == cdb_tag, the entry is written with rdy=1 and data=cdb_data.
- count: next = count + dispatch fire - issue fire. Simultaneous dispatch and issue leave count unchanged.
- disp_ready is derived only from registered count, never from iss_ready.
  - When full, dispatch is refused even if an issue fires in the same cycle. This is a deliberate one-cycle bubble.
- Flush:
  - All entries invalid and count = 0 next cycle.
  - Flush has priority over dispatch, issue and wakeup in the same cycle.
  - iss_valid is not masked combinationally during flush. A fire in the flush cycle is legal and still counts as issued.
- Reset mid-operation: all state is discarded immediately; no partial shifts survive.
- Boundaries:
  - DEPTH entries then dispatch: disp_ready=0, state unchanged.
  - Empty queue with iss_ready=1: no change.
  - Both operands of one entry may match the same CDB tag; both wake.
- Latency: dispatch with both rdy=1 gives iss_valid on the next cycle, provided no older ready entry exists.

Optional Feature:
- Macro: ISSUE_QUEUE_PERF_EN.
- When defined, two extra outputs are added:
  - occupancy [$clog2(DEPTH+1)-1:0]: current count.
  - stall_cnt [15:0]: increments each cycle disp_valid & !disp_ready; saturates at 16'hFFFF; cleared by reset only, not by flush.
- When undefined, neither port nor its logic exists, and the block behaviour is otherwise identical.

Decomposition:
- Package issue_queue_pkg holds:
  - typedef iq_operand_t {tag, rdy, data};
  - typedef iq_entry_t {valid, cmn, rs1, rs2};
  - function operand_wakeup(op, cdb_valid, cdb_tag, cdb_data) returning the updated operand.
- Package types are parametrised via package localparams that mirror the defaults. The top casts widths where needed.
- One natural sub-module, iq_oldest_ready_sel: a DEPTH-wide priority encoder returning the lowest ready index and a found flag.

Test Plan:
- Reset mid-run: 3 entries loaded, rst_n=0 for 1 ns asynchronously → iss_valid=0, queue_full=0, disp_ready=1 immediately.
- Wakeup: dispatch rs1_tag=5 rs1_rdy=0, rs2 ready.
  - CDB tag=5 data=32'hDEAD two cycles later → iss_valid=1 the next cycle with iss_rs1_data=32'hDEAD.
- Dispatch bypass: disp rs1_tag=7 rdy=0 in the same cycle as cdb_tag=7 data=32'h1234 → iss_valid the next cycle, rs1_data=32'h1234.
- Oldest-first: fill DEPTH=4, entries 1 and 3 ready, iss_ready=1 → entry 1 issues first, then old entry 3 (now at index 2). count goes 4→3→2.
- Full plus simultaneous: full queue, iss fire and disp_valid=1 in the same cycle → dispatch refused, count=3. Dispatch accepted the next cycle, count=4.
- Flush: 4 entries, flush=1 with cdb match and disp_valid=1 → next cycle count=0, iss_valid=0.
  - With ISSUE_QUEUE_PERF_EN: 5 refused cycles → stall_cnt=5, retained after flush.
